display_scan_ctrl: RTL and testbench

- Upstream feeder for the common-cathode 7-segment driver. Time-multiplexes a DIGITS-wide packed BCD/hex value onto one shared driver.
- Presents one nibble per slot on `nibble`, with latch-enable `le`, blanking `bl` and lamp-test `lt`. Drives active-low cathode selects `digit_sel_n`.
- Inserts a blanking dead-time between digits to prevent ghosting. Optionally suppresses leading zeros.

---
 rtl/display_pkg.sv | 17 +
 rtl/display_scan_ctrl_if.sv | 28 ++
 rtl/lzb_mask_gen.sv | 21 ++
 rtl/display_scan_ctrl.sv | 101 ++++++++++
 tb/tb_display_scan_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int MAX_DIGITS = 32;

  // Cathode-select pattern with every digit off; callers slice the low DIGITS bits.
  localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

  localparam logic LE_TRANSPARENT = 1'b0;
  localparam logic LE_HOLD        = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side value/control inputs and driver-side scan outputs of the display scan controller.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                lzb_en;
  logic                lamp_test;

  logic [3:0]          nibble;
  logic                le;
  logic                bl;
  logic                lt;
  logic [DIGITS-1:0]   digit_sel_n;
  logic                frame_start;

  modport master (
    output value, load, lzb_en, lamp_test,
    input  nibble, le, bl, lt, digit_sel_n, frame_start
  );

  modport slave (
    input  value, load, lzb_en, lamp_test,
    output nibble, le, bl, lt, digit_sel_n, frame_start
  );

endinterface

// File: rtl/lzb_mask_gen.sv
// Leading-zero blanking mask: digit k is blanked when it and every digit above it are zero.
module lzb_mask_gen #(
  parameter int DIGITS = 4
) (
  input  logic [4*(DIGITS-1)-1:0] upper,   // digits DIGITS-1..1; digit 0 is never blanked
  input  logic                    lzb_en,
  output logic [DIGITS-1:0]       mask
);

  always_comb begin
    logic zero_run;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    mask     = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (upper[4*(k-1) +: 4] == 4'h0);
      mask[k]  = lzb_en & zero_run;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes a packed DIGITS-wide nibble value onto one shared 7-segment driver,
// with a blanking dead-time at the start of every digit slot.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  scan_state_t         state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [4*DIGITS-1:0] pending, active, active_nx;
  logic [DIGITS-1:0]   mask, mask_nx, mask_calc;
  logic                frame_edge;
  logic [4*DIGITS-1:0] frame_value;

  // A load landing on the frame boundary bypasses `pending` so it shows in that frame.
  assign frame_edge  = (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign frame_value = bus.load ? bus.value : pending;

  lzb_mask_gen #(.DIGITS(DIGITS)) u_lzb (
    .upper  (frame_value[4*DIGITS-1:4]),
    .lzb_en (bus.lzb_en),
    .mask   (mask_calc)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    active_nx = active;
    mask_nx   = mask;
    unique case (state)
      BLANK: if (cnt == BLANK_LAST) state_nx = SHOW;
      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
    endcase
    if (frame_edge) begin
      active_nx = frame_value;
      mask_nx   = mask_calc;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BLANK;
      cnt             <= '0;
      idx             <= '0;
      pending         <= '0;
      active          <= '0;
      mask            <= '0;
      bus.nibble      <= '0;
      bus.le          <= LE_TRANSPARENT;
      bus.bl          <= 1'b1;
      bus.lt          <= 1'b0;
      bus.digit_sel_n <= SEL_OFF[DIGITS-1:0];
      bus.frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      active  <= active_nx;
      mask    <= mask_nx;
      if (bus.load) pending <= bus.value;

      bus.nibble      <= active_nx[4*idx_nx +: 4];
      bus.lt          <= bus.lamp_test;
      bus.frame_start <= frame_edge;
      if (state_nx == SHOW) begin
        bus.le          <= LE_HOLD;
        bus.bl          <= mask_nx[idx_nx];
        bus.digit_sel_n <= ~(DIGITS'(1) << idx_nx);
      end else begin
        bus.le          <= LE_TRANSPARENT;
        bus.bl          <= 1'b1;
        bus.digit_sel_n <= SEL_OFF[DIGITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a time-based reference model compared every cycle,
// plus directed literal checks for reset, scan order, leading-zero blanking, loads and lamp test.
module tb_display_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = DIGITS * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  display_scan_ctrl #(
    .DIGITS       (DIGITS),
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: everything derives from cycles since reset ----------------
  int                  t = 0;
  logic [4*DIGITS-1:0] m_pending = '0;
  logic [4*DIGITS-1:0] m_active  = '0;
  logic [DIGITS-1:0]   m_mask    = '0;
  logic                m_lt      = 1'b0;

  function automatic logic [DIGITS-1:0] lzb_of(input logic [4*DIGITS-1:0] v, input logic en);
    lzb_of = '0;
    for (int k = 1; k < DIGITS; k++) lzb_of[k] = en && ((v >> (4*k)) == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t         <= 0;
      m_pending <= '0;
      m_active  <= '0;
      m_mask    <= '0;
      m_lt      <= 1'b0;
    end else begin
      t <= t + 1;
      if ((t + 1) % FRAME == 0) begin
        m_active <= bus.load ? bus.value : m_pending;
        m_mask   <= lzb_of(bus.load ? bus.value : m_pending, bus.lzb_en);
      end
      if (bus.load) m_pending <= bus.value;
      m_lt <= bus.lamp_test;
    end
  end

  always @(negedge clk) begin : cmp
    int                slot, phase;
    logic              show;
    logic [3:0]        e_nib;
    logic [DIGITS-1:0] e_sel;
    logic              e_bl, e_fs;
    slot  = (t / CLK_DIV) % DIGITS;
    phase = t % CLK_DIV;
    show  = phase >= BLANK_CYCLES;
    e_nib = 4'((m_active >> (4*slot)) & 'hf);
    e_sel = show ? ~(DIGITS'(1) << slot) : {DIGITS{1'b1}};
    e_bl  = show ? m_mask[slot] : 1'b1;
    e_fs  = (t > 0) && (t % FRAME == 0);
    check($sformatf("scan t=%0d {nib,le,bl,lt,sel,fs}", t),
          32'({bus.nibble, bus.le, bus.bl, bus.lt, bus.digit_sel_n, bus.frame_start}),
          32'({e_nib, show, e_bl, m_lt, e_sel, e_fs}));
  end

  // ---------------- stimulus helpers (called right after a falling edge) ----------------
  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_val(input logic [4*DIGITS-1:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 4 * FRAME);
    check("frame_start_seen", 32'(bus.frame_start), 32'd1);
  endtask

  task automatic expect_slot(input string name, input logic [3:0] nib, input logic [3:0] sel,
                             input logic le, input logic bl);
    check({name, "_nibble"}, 32'(bus.nibble), 32'(nib));
    check({name, "_sel"},    32'(bus.digit_sel_n), 32'(sel));
    check({name, "_le"},     32'(bus.le), 32'(le));
    check({name, "_bl"},     32'(bus.bl), 32'(bl));
  endtask

  task automatic expect_reset(input string name);
    expect_slot(name, 4'h0, 4'hf, 1'b0, 1'b1);
    check({name, "_lt"}, 32'(bus.lt), 32'd0);
    check({name, "_fs"}, 32'(bus.frame_start), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.value     = '0;
    bus.load      = 1'b0;
    bus.lzb_en    = 1'b0;
    bus.lamp_test = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held while inputs toggle
    repeat (3) begin
      @(negedge clk);
      bus.value     = 16'($urandom);
      bus.load      = 1'b1;
      bus.lamp_test = ~bus.lamp_test;
    end
    @(posedge clk); #1;
    expect_reset("rst_hold");

    @(negedge clk);
    bus.load = 1'b0; bus.lamp_test = 1'b0; bus.value = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_c1_sel", 32'(bus.digit_sel_n), 32'hf);
    @(posedge clk); #1;
    check("post_rst_c2_sel", 32'(bus.digit_sel_n), 32'he);
    check("post_rst_c2_le",  32'(bus.le), 32'd1);

    // Basic scan of 1234
    @(negedge clk);
    load_val(16'h1234);
    wait_frame();
    expect_slot("s0_blank", 4'h4, 4'hf, 1'b0, 1'b1);
    advance(2);  expect_slot("s0_show", 4'h4, 4'he, 1'b1, 1'b0);
    advance(8);  expect_slot("s1_show", 4'h3, 4'hd, 1'b1, 1'b0);
    advance(8);  expect_slot("s2_show", 4'h2, 4'hb, 1'b1, 1'b0);
    advance(8);  expect_slot("s3_show", 4'h1, 4'h7, 1'b1, 1'b0);
    wait_frame();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.frame_start && n < 4 * FRAME);
      check("frame_period", 32'(n), 32'd32);
    end

    // Mid-frame load does not tear the current frame
    advance(19);
    load_val(16'hABCD);
    advance(8);  expect_slot("tear_s3", 4'h1, 4'h7, 1'b1, 1'b0);
    wait_frame(); check("tear_next_d", 32'(bus.nibble), 32'hd);
    advance(10); expect_slot("tear_next_s1", 4'hc, 4'hd, 1'b1, 1'b0);

    // Load on the boundary edge shows in the same frame
    wait_frame();
    advance(31);
    load_val(16'h5678);
    check("bypass_fs",     32'(bus.frame_start), 32'd1);
    check("bypass_nibble", 32'(bus.nibble), 32'h8);
    advance(2);  expect_slot("bypass_s0", 4'h8, 4'he, 1'b1, 1'b0);

    // Leading-zero blanking
    bus.lzb_en = 1'b1;
    load_val(16'h0050);
    wait_frame();
    advance(2);  expect_slot("lzb_s0", 4'h0, 4'he, 1'b1, 1'b0);
    advance(8);  expect_slot("lzb_s1", 4'h5, 4'hd, 1'b1, 1'b0);
    advance(8);  expect_slot("lzb_s2", 4'h0, 4'hb, 1'b1, 1'b1);
    advance(8);  expect_slot("lzb_s3", 4'h0, 4'h7, 1'b1, 1'b1);
    load_val(16'h0000);
    wait_frame();
    advance(2);  expect_slot("lzb0_s0", 4'h0, 4'he, 1'b1, 1'b0);
    advance(8);  expect_slot("lzb0_s1", 4'h0, 4'hd, 1'b1, 1'b1);
    bus.lzb_en = 1'b0;

    // Lamp test latency
    @(negedge clk);
    bus.lamp_test = 1'b1;
    #1 check("lt_before_edge", 32'(bus.lt), 32'd0);
    @(negedge clk); check("lt_on", 32'(bus.lt), 32'd1);
    bus.lamp_test = 1'b0;
    #1 check("lt_hold", 32'(bus.lt), 32'd1);
    @(negedge clk); check("lt_off", 32'(bus.lt), 32'd0);

    // Randomized traffic, checked every cycle by the model
    repeat (2500) begin
      @(negedge clk);
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.value     = 16'($urandom >> $urandom_range(16, 32));
      bus.lamp_test = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) bus.lzb_en = ~bus.lzb_en;
    end
    bus.load = 1'b0; bus.lamp_test = 1'b0; bus.lzb_en = 1'b0;

    // Asynchronous reset in the middle of a SHOW phase
    load_val(16'h1234);
    wait_frame();
    advance(13);
    expect_slot("pre_async_s1", 4'h3, 4'hd, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_reset("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_c1_sel", 32'(bus.digit_sel_n), 32'hf);
    @(posedge clk); #1;
    check("restart_c2_sel",    32'(bus.digit_sel_n), 32'he);
    check("restart_c2_nibble", 32'(bus.nibble), 32'h0);
    advance(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
